// File: rtl/game_state_ctl.sv
// rtl/game_state_ctl.sv - frame-aligned game state controller (START / LEVEL_1 / FINISH)

package state_pkg;
   typedef enum logic [1:0] {
      START   = 2'd0,
      LEVEL_1 = 2'd1,
      FINISH  = 2'd2
   } g_state;
endpackage

module game_state_ctl
   import state_pkg::*;
#(
   parameter int START_BTN_X   = 350,
   parameter int START_BTN_Y   = 250,
   parameter int START_BTN_W   = 100,
   parameter int START_BTN_H   = 50,
   parameter int EXIT_X        = 700,
   parameter int EXIT_Y        = 500,
   parameter int EXIT_W        = 60,
   parameter int EXIT_H        = 60,
   parameter int HOLD_FRAMES   = 3,
   parameter int FINISH_FRAMES = 180
) (
   input  logic        clk_40,
   input  logic        rst,
   input  logic        vsync,
   input  logic        mouse_left,
   input  logic [11:0] xpos_mouse,
   input  logic [11:0] ypos_mouse,
   input  logic [11:0] xpos_player,
   input  logic [11:0] ypos_player,
   input  logic        button_pressed,
   output g_state      game_state,
   output logic        level_start,
   output logic        state_changed
);

   // Hit-box bounds widened to 13 bits so edge+size cannot wrap.
   localparam logic [12:0] BTN_X0  = 13'(START_BTN_X);
   localparam logic [12:0] BTN_X1  = 13'(START_BTN_X + START_BTN_W);
   localparam logic [12:0] BTN_Y0  = 13'(START_BTN_Y);
   localparam logic [12:0] BTN_Y1  = 13'(START_BTN_Y + START_BTN_H);
   localparam logic [12:0] EXIT_X0 = 13'(EXIT_X);
   localparam logic [12:0] EXIT_X1 = 13'(EXIT_X + EXIT_W);
   localparam logic [12:0] EXIT_Y0 = 13'(EXIT_Y);
   localparam logic [12:0] EXIT_Y1 = 13'(EXIT_Y + EXIT_H);
   localparam logic [7:0]  HOLD_N  = 8'(HOLD_FRAMES);
   localparam logic [7:0]  FIN_N   = 8'(FINISH_FRAMES);

   g_state     state, state_nxt;
   logic       vsync_q, mouse_left_q;
   logic       pending, pending_nxt;
   logic [7:0] hold_cnt, hold_nxt;
   logic [7:0] fin_cnt, fin_nxt;
   logic       level_start_nxt, changed_nxt;

   logic       frame_tick, click, in_btn, in_exit;
   logic [7:0] hold_inc, fin_inc;

   assign frame_tick = vsync & ~vsync_q;
   assign click      = mouse_left & ~mouse_left_q;

   assign in_btn  = ({1'b0, xpos_mouse} >= BTN_X0) && ({1'b0, xpos_mouse} < BTN_X1) &&
                    ({1'b0, ypos_mouse} >= BTN_Y0) && ({1'b0, ypos_mouse} < BTN_Y1);
   assign in_exit = ({1'b0, xpos_player} >= EXIT_X0) && ({1'b0, xpos_player} < EXIT_X1) &&
                    ({1'b0, ypos_player} >= EXIT_Y0) && ({1'b0, ypos_player} < EXIT_Y1);

   // Counters saturate at 255 instead of wrapping.
   assign hold_inc = (hold_cnt == 8'hFF) ? 8'hFF : hold_cnt + 8'd1;
   assign fin_inc  = (fin_cnt  == 8'hFF) ? 8'hFF : fin_cnt  + 8'd1;

   assign game_state = state;

   // Registers: edge-detect history, state, request flag, counters and pulses.
   always_ff @(posedge clk_40 or posedge rst) begin
      if (rst) begin
         state         <= START;
         vsync_q       <= 1'b0;
         mouse_left_q  <= 1'b0;
         pending       <= 1'b0;
         hold_cnt      <= 8'd0;
         fin_cnt       <= 8'd0;
         level_start   <= 1'b0;
         state_changed <= 1'b0;
      end else begin
         state         <= state_nxt;
         vsync_q       <= vsync;
         mouse_left_q  <= mouse_left;
         pending       <= pending_nxt;
         hold_cnt      <= hold_nxt;
         fin_cnt       <= fin_nxt;
         level_start   <= level_start_nxt;
         state_changed <= changed_nxt;
      end
   end

   // Next state: a request raised in one frame commits at the following frame tick.
   always_comb begin
      state_nxt       = state;
      pending_nxt     = pending;
      hold_nxt        = hold_cnt;
      fin_nxt         = fin_cnt;
      level_start_nxt = 1'b0;
      changed_nxt     = 1'b0;
      case (state)
         START: begin
            if (frame_tick && pending) begin
               state_nxt       = LEVEL_1;
               level_start_nxt = 1'b1;
               changed_nxt     = 1'b1;
            end else if (click && in_btn) begin
               pending_nxt = 1'b1;
            end
         end
         LEVEL_1: begin
            if (frame_tick && pending) begin
               state_nxt   = FINISH;
               changed_nxt = 1'b1;
            end else if (frame_tick) begin
               if (in_exit && button_pressed) begin
                  hold_nxt = hold_inc;
                  if (hold_inc == HOLD_N)
                     pending_nxt = 1'b1;
               end else begin
                  hold_nxt = 8'd0;
               end
            end
         end
         FINISH: begin
            if (frame_tick && pending) begin
               state_nxt   = START;
               changed_nxt = 1'b1;
            end else begin
               if (frame_tick) begin
                  fin_nxt = fin_inc;
                  if (fin_inc == FIN_N)
                     pending_nxt = 1'b1;
               end
               if (click)
                  pending_nxt = 1'b1;
            end
         end
         default: begin
            state_nxt   = START;
            changed_nxt = 1'b1;
         end
      endcase
      // Every transition starts the new state with a clean slate.
      if (changed_nxt) begin
         pending_nxt = 1'b0;
         hold_nxt    = 8'd0;
         fin_nxt     = 8'd0;
      end
   end

endmodule

// File: tb/tb_game_state_ctl.sv
// tb/tb_game_state_ctl.sv - directed self-checking bench for game_state_ctl
`timescale 1ns/1ps
module tb_game_state_ctl;
   import state_pkg::*;

   logic        clk_40 = 1'b0;
   logic        rst = 1'b1;
   logic        vsync = 1'b0;
   logic        mouse_left = 1'b0;
   logic [11:0] xpos_mouse = 12'd0, ypos_mouse = 12'd0;
   logic [11:0] xpos_player = 12'd0, ypos_player = 12'd0;
   logic        button_pressed = 1'b0;
   g_state      game_state;
   logic        level_start, state_changed;

   int vectors = 0;
   int miscompares = 0;

   g_state st_after;
   logic   ls_after, sc_after, ls_next, sc_next;

   game_state_ctl dut (
      .clk_40(clk_40), .rst(rst), .vsync(vsync), .mouse_left(mouse_left),
      .xpos_mouse(xpos_mouse), .ypos_mouse(ypos_mouse),
      .xpos_player(xpos_player), .ypos_player(ypos_player),
      .button_pressed(button_pressed), .game_state(game_state),
      .level_start(level_start), .state_changed(state_changed)
   );

   always #12 clk_40 = ~clk_40;

   initial begin
      #2000000;
      $display("FAIL watchdog: time limit reached, required completion");
      $fatal(1, "watchdog");
   end

   task do_reset();
      rst = 1'b1; vsync = 1'b0; mouse_left = 1'b0; button_pressed = 1'b0;
      repeat (2) @(negedge clk_40);
      rst = 1'b0;
      repeat (2) @(negedge clk_40);
   endtask

   // One frame: vsync rises at a negedge, outputs sampled #1 after the next two posedges.
   task tick();
      @(negedge clk_40); vsync = 1'b1;
      @(posedge clk_40); #1;
      st_after = game_state; ls_after = level_start; sc_after = state_changed;
      @(negedge clk_40); vsync = 1'b0;
      @(posedge clk_40); #1;
      ls_next = level_start; sc_next = state_changed;
      repeat (3) @(negedge clk_40);
   endtask

   task click_at(input int x, input int y);
      xpos_mouse = 12'(x); ypos_mouse = 12'(y);
      @(negedge clk_40); mouse_left = 1'b1;
      @(negedge clk_40); mouse_left = 1'b0;
      @(negedge clk_40);
   endtask

   task chk_state(input string name, input g_state exp);
      vectors++;
      if (game_state !== exp) begin
         miscompares++;
         $display("FAIL %s: game_state=%0d expected %0d", name, game_state, exp);
      end
   endtask

   task goto_level();
      do_reset();
      click_at(400, 270);
      tick();
   endtask

   task test_reset();
      rst = 1'b1;
      repeat (2) @(negedge clk_40);
      vectors++;
      if (game_state !== START || level_start !== 1'b0 || state_changed !== 1'b0) begin
         miscompares++;
         $display("FAIL reset: state=%0d ls=%b sc=%b expected 0 0 0", game_state, level_start, state_changed);
      end
      do_reset();
   endtask

   task test_start_click();
      do_reset();
      click_at(400, 270);
      vectors++;
      if (dut.pending !== 1'b1) begin
         miscompares++;
         $display("FAIL click_pending: pending=%b expected 1", dut.pending);
      end
      tick();
      vectors++;
      if (st_after !== LEVEL_1 || ls_after !== 1'b1 || sc_after !== 1'b1) begin
         miscompares++;
         $display("FAIL start_commit: state=%0d ls=%b sc=%b expected 1 1 1", st_after, ls_after, sc_after);
      end
      vectors++;
      if (ls_next !== 1'b0 || sc_next !== 1'b0) begin
         miscompares++;
         $display("FAIL start_pulse_width: ls=%b sc=%b expected 0 0", ls_next, sc_next);
      end
   endtask

   task test_btn_edges();
      do_reset();
      click_at(349, 270);
      repeat (3) tick();
      chk_state("miss_x349", START);
      click_at(450, 270);
      repeat (3) tick();
      chk_state("miss_x450", START);
      click_at(400, 249);
      repeat (3) tick();
      chk_state("miss_y249", START);
      click_at(350, 270);
      tick();
      chk_state("hit_x350", LEVEL_1);
      do_reset();
      click_at(449, 299);
      tick();
      chk_state("hit_x449_y299", LEVEL_1);
   endtask

   task test_exit_hold();
      goto_level();
      xpos_player = 12'd710; ypos_player = 12'd510; button_pressed = 1'b1;
      repeat (3) tick();
      chk_state("hold_3_ticks", LEVEL_1);
      tick();
      vectors++;
      if (st_after !== FINISH || sc_after !== 1'b1 || ls_after !== 1'b0) begin
         miscompares++;
         $display("FAIL finish_commit: state=%0d sc=%b ls=%b expected 2 1 0", st_after, sc_after, ls_after);
      end
      // Interrupted hold: two good frames, one outside, then a fresh run of three.
      goto_level();
      xpos_player = 12'd710; ypos_player = 12'd510; button_pressed = 1'b1;
      repeat (2) tick();
      xpos_player = 12'd600;
      tick();
      xpos_player = 12'd710;
      repeat (3) tick();
      chk_state("hold_restart_3", LEVEL_1);
      tick();
      chk_state("hold_restart_commit", FINISH);
      button_pressed = 1'b0;
   endtask

   task test_finish_timeout();
      goto_level();
      xpos_player = 12'd710; ypos_player = 12'd510; button_pressed = 1'b1;
      repeat (4) tick();
      button_pressed = 1'b0;
      chk_state("fin_entry", FINISH);
      repeat (180) tick();
      chk_state("fin_180_ticks", FINISH);
      tick();
      chk_state("fin_181_ticks", START);
   endtask

   task test_finish_click();
      goto_level();
      xpos_player = 12'd710; ypos_player = 12'd510; button_pressed = 1'b1;
      repeat (4) tick();
      button_pressed = 1'b0;
      repeat (10) tick();
      chk_state("fin_click_before", FINISH);
      click_at(5, 5);
      tick();
      chk_state("fin_click_commit", START);
   endtask

   task test_same_cycle();
      do_reset();
      xpos_mouse = 12'd400; ypos_mouse = 12'd270;
      @(negedge clk_40); mouse_left = 1'b1; vsync = 1'b1;
      @(posedge clk_40); #1;
      chk_state("same_cycle_tick", START);
      @(negedge clk_40); mouse_left = 1'b0; vsync = 1'b0;
      repeat (3) @(negedge clk_40);
      chk_state("same_cycle_after", START);
      tick();
      chk_state("same_cycle_next_frame", LEVEL_1);
   endtask

   task test_reset_mid();
      goto_level();
      xpos_player = 12'd710; ypos_player = 12'd510; button_pressed = 1'b1;
      repeat (2) tick();
      vectors++;
      if (dut.hold_cnt !== 8'd2) begin
         miscompares++;
         $display("FAIL hold_cnt_2: hold_cnt=%0d expected 2", dut.hold_cnt);
      end
      @(posedge clk_40); #5;
      rst = 1'b1;
      #1;
      vectors++;
      if (game_state !== START || dut.hold_cnt !== 8'd0 || dut.fin_cnt !== 8'd0 ||
          dut.pending !== 1'b0 || level_start !== 1'b0) begin
         miscompares++;
         $display("FAIL async_reset: state=%0d hold=%0d fin=%0d pend=%b ls=%b expected 0 0 0 0 0",
                  game_state, dut.hold_cnt, dut.fin_cnt, dut.pending, level_start);
      end
      button_pressed = 1'b0;
      do_reset();
   endtask

   initial begin
      test_reset();
      test_start_click();
      test_btn_edges();
      test_exit_hold();
      test_finish_timeout();
      test_finish_click();
      test_same_cycle();
      test_reset_mid();
      $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
      $finish;
   end

endmodule
